// File: rtl/pixel_pkg.sv
// Shared definitions for the VGA pixel-port arbitration slice: screen
// geometry, coordinate/colour widths, requester ids and arbiter states.
package pixel_pkg;

   // Pixel bus widths as seen by vga_adapter.
   localparam int X_W = 9;
   localparam int Y_W = 8;
   localparam int C_W = 3;

   // Visible area; anything at or beyond these bounds is clipped.
   localparam int SCREEN_W = 320;
   localparam int SCREEN_H = 240;

   // Requester slots on the shared port.
   localparam int REQ_SCREEN = 0;
   localparam int REQ_USER   = 1;
   localparam int REQ_BULLET = 2;
   localparam int REQ_ENEMY  = 3;

   // Arbiter states: waiting for a request, or a burst owns the port.
   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } arb_state_e;

   // Full-width unsigned clip test; x in 320..511 and y in 240..255 fail.
   function automatic logic on_screen(input logic [X_W-1:0] x,
                                      input logic [Y_W-1:0] y);
      return (32'(x) < 32'(SCREEN_W)) && (32'(y) < 32'(SCREEN_H));
   endfunction

endpackage

// File: rtl/pixel_port_arbiter_rr_picker.sv
// Combinational round-robin picker: starting just after last_winner and
// wrapping around, return the first set request as one-hot and as index.
// Generic enough to reuse for any shared resource.
module rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   last_winner_i,
   output logic [NUM_REQ-1:0] pick_o,
   output logic [IDX_W-1:0]   pick_idx_o,
   output logic               any_o
);

   int cand;

   // Scan offsets 1..NUM_REQ from the previous winner; the previous winner
   // itself is visited last, so it has the lowest priority.
   always_comb begin
      pick_o     = '0;
      pick_idx_o = '0;
      any_o      = 1'b0;
      cand       = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = int'(last_winner_i) + k;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         if (!any_o && req_i[cand]) begin
            any_o        = 1'b1;
            pick_o[cand] = 1'b1;
            pick_idx_o   = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/pixel_port_arbiter.sv
// Shares the single VGA pixel write port between sprite drawers.
// One burst owns the port at a time (round-robin between bursts); the
// owner's pixels are clipped and forwarded to vga_adapter through one
// register stage. A watchdog reclaims the port from a hung burst.
//
// Handshake: pix_ready equals grant. A pixel transfers on a clock edge
// where pix_valid[i] & pix_ready[i] & req[i] are all high; a requester
// that drops req forfeits any pixel presented in that same cycle.
module pixel_port_arbiter
   import pixel_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int MAX_BURST = 1024
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [NUM_REQ-1:0]     pix_valid,
   input  logic [NUM_REQ-1:0]     pix_last,
   input  logic [NUM_REQ*X_W-1:0] pix_x,
   input  logic [NUM_REQ*Y_W-1:0] pix_y,
   input  logic [NUM_REQ*C_W-1:0] pix_colour,
   output logic [NUM_REQ-1:0]     grant,
   output logic [NUM_REQ-1:0]     pix_ready,
   output logic [X_W-1:0]         vga_x,
   output logic [Y_W-1:0]         vga_y,
   output logic [C_W-1:0]         vga_colour,
   output logic                   vga_plot,
   output logic                   busy,
   output logic                   timeout_err
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WD_W  = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MAX_BURST - 1);
   localparam logic [WD_W-1:0] WD_SAT   = '1;

   // Arbiter state and registered outputs.
   arb_state_e          state_q;
   logic [NUM_REQ-1:0]  grant_q;
   logic [IDX_W-1:0]    last_winner_q;
   logic [WD_W-1:0]     wd_q;
   logic [WD_W-1:0]     wd_d;
   logic                busy_q;
   logic                timeout_q;

   // Pixel output stage.
   logic [X_W-1:0]      vga_x_q;
   logic [Y_W-1:0]      vga_y_q;
   logic [C_W-1:0]      vga_colour_q;
   logic                vga_plot_q;

   // Picker results.
   logic [NUM_REQ-1:0]  pick;
   logic [IDX_W-1:0]    pick_idx;
   logic                pick_any;

   // Granted requester's view of the bus (index is last_winner_q).
   logic                g_req;
   logic                g_valid;
   logic                g_last;
   logic [X_W-1:0]      sel_x;
   logic [Y_W-1:0]      sel_y;
   logic [C_W-1:0]      sel_colour;

   // Per-cycle burst events.
   logic                in_grant;
   logic                accept;
   logic                burst_done;
   logic                req_drop;
   logic                wd_expire;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req_i         (req),
      .last_winner_i (last_winner_q),
      .pick_o        (pick),
      .pick_idx_o    (pick_idx),
      .any_o         (pick_any)
   );

   // Select the owner's request, handshake and pixel fields; non-owners
   // are never looked at.
   always_comb begin
      g_req      = req[last_winner_q];
      g_valid    = pix_valid[last_winner_q];
      g_last     = pix_last[last_winner_q];
      sel_x      = pix_x[last_winner_q*X_W +: X_W];
      sel_y      = pix_y[last_winner_q*Y_W +: Y_W];
      sel_colour = pix_colour[last_winner_q*C_W +: C_W];
   end

   // Burst end conditions. A dropped request beats everything, including
   // a last pixel in the same cycle; the watchdog only fires when the burst
   // is not already ending on its own.
   always_comb begin
      in_grant   = (state_q == S_GRANT);
      accept     = in_grant & g_req & g_valid;
      burst_done = accept & g_last;
      req_drop   = in_grant & ~g_req;
      wd_expire  = in_grant & g_req & ~burst_done & (wd_q == WD_LIMIT);
      wd_d       = (wd_q == WD_SAT) ? wd_q : wd_q + 1'b1;
   end

   // Arbiter FSM: grant on the edge after a request, release after the
   // last pixel, a dropped request or watchdog expiry. Idle always lasts
   // at least one cycle between bursts.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         grant_q       <= '0;
         last_winner_q <= IDX_W'(NUM_REQ - 1);
         wd_q          <= '0;
         busy_q        <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               grant_q <= '0;
               busy_q  <= 1'b0;
               if (pick_any) begin
                  state_q       <= S_GRANT;
                  grant_q       <= pick;
                  last_winner_q <= pick_idx;
                  wd_q          <= '0;
                  busy_q        <= 1'b1;
               end
            end
            S_GRANT: begin
               if (req_drop || burst_done || wd_expire) begin
                  state_q <= S_IDLE;
                  grant_q <= '0;
                  busy_q  <= 1'b0;
                  if (wd_expire) begin
                     timeout_q <= 1'b1;
                  end
               end else begin
                  wd_q <= wd_d;
               end
            end
            default: begin
               state_q <= S_IDLE;
               grant_q <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Output stage: accepted pixels always update the coordinates/colour;
   // the strobe is raised only for on-screen pixels, and only for one cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vga_x_q      <= '0;
         vga_y_q      <= '0;
         vga_colour_q <= '0;
         vga_plot_q   <= 1'b0;
      end else begin
         vga_plot_q <= accept & on_screen(sel_x, sel_y);
         if (accept) begin
            vga_x_q      <= sel_x;
            vga_y_q      <= sel_y;
            vga_colour_q <= sel_colour;
         end
      end
   end

   assign grant       = grant_q;
   assign pix_ready   = grant_q;
   assign busy        = busy_q;
   assign timeout_err = timeout_q;
   assign vga_x       = vga_x_q;
   assign vga_y       = vga_y_q;
   assign vga_colour  = vga_colour_q;
   assign vga_plot    = vga_plot_q;

endmodule

// File: tb/tb_pixel_port_arbiter.sv
// Bench for pixel_port_arbiter: directed scenarios followed by random
// traffic, every cycle compared against a burst-level reference model.
module tb_pixel_port_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int MAX_BURST = 1024;
   localparam int X_W       = 9;
   localparam int Y_W       = 8;
   localparam int C_W       = 3;
   localparam int W         = X_W + Y_W + C_W;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [NUM_REQ-1:0]     req;
   logic [NUM_REQ-1:0]     pix_valid;
   logic [NUM_REQ-1:0]     pix_last;
   logic [NUM_REQ*X_W-1:0] pix_x;
   logic [NUM_REQ*Y_W-1:0] pix_y;
   logic [NUM_REQ*C_W-1:0] pix_colour;
   logic [NUM_REQ-1:0]     grant;
   logic [NUM_REQ-1:0]     pix_ready;
   logic [X_W-1:0]         vga_x;
   logic [Y_W-1:0]         vga_y;
   logic [C_W-1:0]         vga_colour;
   logic                   vga_plot;
   logic                   busy;
   logic                   timeout_err;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: who owns the port, how long it has had it, and what
   // the adapter should currently be seeing.
   int                     m_owner;
   int                     m_last;
   int                     m_cnt;
   logic                   m_err;
   logic                   m_plot;
   logic [X_W-1:0]         m_x;
   logic [Y_W-1:0]         m_y;
   logic [C_W-1:0]         m_c;
   logic [W-1:0]           exp_q[$];
   int                     grant_log[$];

   pixel_port_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .pix_valid   (pix_valid),
      .pix_last    (pix_last),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .pix_colour  (pix_colour),
      .grant       (grant),
      .pix_ready   (pix_ready),
      .vga_x       (vga_x),
      .vga_y       (vga_y),
      .vga_colour  (vga_colour),
      .vga_plot    (vga_plot),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   // Clock and a hard time limit.
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, n_errors=%0d", n_errors);
      $fatal(1, "global timeout");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Driver helpers.
   task automatic set_pix(input int i, input logic v, input logic l,
                          input int x, input int y, input int c);
      pix_valid[i]            = v;
      pix_last[i]             = l;
      pix_x[i*X_W +: X_W]     = X_W'(x);
      pix_y[i*Y_W +: Y_W]     = Y_W'(y);
      pix_colour[i*C_W +: C_W] = C_W'(c);
   endtask

   task automatic clr_pix();
      pix_valid = '0;
      pix_last  = '0;
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_last  = NUM_REQ - 1;
      m_cnt   = 0;
      m_err   = 1'b0;
      m_plot  = 1'b0;
      m_x     = '0;
      m_y     = '0;
      m_c     = '0;
      exp_q.delete();
   endtask

   // One clock edge of the rules: arbitrate when free, otherwise let the
   // owner transfer a pixel and decide whether its burst is over.
   task automatic model_step();
      logic [X_W-1:0] x;
      logic [Y_W-1:0] y;
      logic [C_W-1:0] c;
      int g;
      int cand;
      m_plot = 1'b0;
      if (m_owner < 0) begin
         for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (m_last + k) % NUM_REQ;
            if (m_owner < 0 && req[cand]) m_owner = cand;
         end
         if (m_owner >= 0) begin
            m_last = m_owner;
            m_cnt  = 0;
         end
      end else begin
         g = m_owner;
         if (!req[g]) begin
            m_owner = -1;
         end else begin
            if (pix_valid[g]) begin
               x = pix_x[g*X_W +: X_W];
               y = pix_y[g*Y_W +: Y_W];
               c = pix_colour[g*C_W +: C_W];
               m_x = x;
               m_y = y;
               m_c = c;
               m_plot = (int'(x) < 320) && (int'(y) < 240);
               if (m_plot) exp_q.push_back({x, y, c});
            end
            if (pix_valid[g] && pix_last[g]) begin
               m_owner = -1;
            end else if (m_cnt == MAX_BURST - 1) begin
               m_owner = -1;
               m_err   = 1'b1;
            end else begin
               m_cnt++;
            end
         end
      end
   endtask

   // Scoreboard: compare every DUT output with the model.
   task automatic check_outputs();
      logic [NUM_REQ-1:0] eg;
      logic [W-1:0] item;
      eg = (m_owner < 0) ? '0 : NUM_REQ'(1 << m_owner);
      check_eq("grant", grant, eg);
      check_eq("pix_ready", pix_ready, eg);
      check_eq("busy", busy, (m_owner >= 0));
      check_eq("timeout_err", timeout_err, m_err);
      check_eq("vga_plot", vga_plot, m_plot);
      check_eq("vga_x", vga_x, m_x);
      check_eq("vga_y", vga_y, m_y);
      check_eq("vga_colour", vga_colour, m_c);
      if (m_plot) begin
         item = exp_q.pop_front();
         check_eq("sb_pixel", {vga_x, vga_y, vga_colour}, item);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check_outputs();
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
      int r;
      r = -1;
      for (int i = 0; i < NUM_REQ; i++) if (v[i]) r = i;
      return r;
   endfunction

   initial begin
      int hi;
      int plots[4];
      int xs_seen[4];
      int t3_x[4] = '{319, 320, 5, 0};
      int t3_y[4] = '{239, 10, 240, 0};
      int t3_l[4] = '{0, 0, 0, 1};
      int t3_p[4] = '{1, 0, 0, 1};

      reset      = 1'b1;
      req        = '0;
      pix_valid  = '0;
      pix_last   = '0;
      pix_x      = '0;
      pix_y      = '0;
      pix_colour = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_grant", grant, 0);
      check_eq("rst_plot", vga_plot, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_timeout", timeout_err, 0);
      check_eq("rst_vga_x", vga_x, 0);
      @(negedge clk);
      reset = 1'b0;

      // Test 1: single three-pixel burst from requester 1.
      req = 4'b0010;
      cycle();
      check_eq("t1_grant", grant, 4'b0010);
      set_pix(1, 1, 0, 10, 20, 5);
      cycle();
      check_eq("t1_x0", vga_x, 10);
      set_pix(1, 1, 0, 11, 20, 5);
      cycle();
      check_eq("t1_x1", vga_x, 11);
      set_pix(1, 1, 1, 12, 20, 5);
      cycle();
      check_eq("t1_x2", vga_x, 12);
      check_eq("t1_plot2", vga_plot, 1);
      check_eq("t1_grant_end", grant, 0);
      req = '0;
      clr_pix();
      cycle();

      // Test 2: all requesting, one-pixel bursts rotate 0,1,2,3,0.
      apply_reset();
      req = 4'b1111;
      for (int i = 0; i < NUM_REQ; i++) set_pix(i, 1, 1, i * 10, i * 5, i);
      grant_log.delete();
      for (int n = 0; n < 10; n++) begin
         cycle();
         if (grant != 0) grant_log.push_back(onehot_idx(grant));
      end
      check_eq("t2_grant_count", grant_log.size(), 5);
      for (int i = 0; i < grant_log.size(); i++) check_eq("t2_order", grant_log[i], i % NUM_REQ);
      req = '0;
      clr_pix();
      cycle();

      // Test 3: clipping at the screen edges.
      req = 4'b0001;
      cycle();
      for (int i = 0; i < 4; i++) begin
         set_pix(0, 1, t3_l[i][0], t3_x[i], t3_y[i], 3);
         cycle();
         plots[i]   = int'(vga_plot);
         xs_seen[i] = int'(vga_x);
      end
      for (int i = 0; i < 4; i++) check_eq("t3_plot", plots[i], t3_p[i]);
      check_eq("t3_x_first", xs_seen[0], 319);
      check_eq("t3_x_last", xs_seen[3], 0);
      req = '0;
      clr_pix();
      cycle();

      // Test 4: hung burst from requester 2 trips the watchdog.
      req = 4'b0100;
      hi  = 0;
      cycle();
      while (grant == 4'b0100 && hi < MAX_BURST + 8) begin
         hi++;
         cycle();
      end
      check_eq("t4_grant_cycles", hi, MAX_BURST);
      check_eq("t4_timeout", timeout_err, 1);
      req = '0;
      cycle();
      req = 4'b0001;
      cycle();
      set_pix(0, 1, 1, 3, 4, 2);
      cycle();
      req = '0;
      clr_pix();
      cycle();
      check_eq("t4_err_sticky", timeout_err, 1);

      // Test 5: requester 3 drops req while presenting a last pixel.
      req = 4'b1000;
      cycle();
      check_eq("t5_grant3", grant, 4'b1000);
      set_pix(3, 1, 0, 40, 40, 6);
      req = 4'b1010;
      cycle();
      req = 4'b0010;
      set_pix(3, 1, 1, 50, 41, 6);
      cycle();
      check_eq("t5_no_plot", vga_plot, 0);
      check_eq("t5_idle", busy, 0);
      clr_pix();
      cycle();
      check_eq("t5_next", grant, 4'b0010);
      req = '0;
      cycle();
      cycle();

      // Test 6: asynchronous reset mid-burst.
      req = 4'b0001;
      set_pix(0, 1, 0, 7, 7, 1);
      cycle();
      cycle();
      check_eq("t6_plot_before", vga_plot, 1);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_eq("t6_rst_grant", grant, 0);
      check_eq("t6_rst_plot", vga_plot, 0);
      check_eq("t6_rst_busy", busy, 0);
      check_eq("t6_rst_timeout", timeout_err, 0);
      check_eq("t6_rst_vga_x", vga_x, 0);
      check_eq("t6_rst_vga_y", vga_y, 0);
      @(negedge clk);
      reset = 1'b0;
      req   = 4'b1111;
      clr_pix();
      cycle();
      check_eq("t6_first_after_reset", grant, 4'b0001);
      req = '0;
      cycle();
      cycle();

      // Random traffic: requests toggle, pixels and last flags random.
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
            set_pix(i, ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0),
                    int'($urandom_range(0, 511)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 7)));
         end
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
